mem_port_arbiter: RTL and testbench

//  Sequences the single shared CPU memory (data words 0-1023, instructions at byte addr >=1024)

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_rr.sv | 22 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_DATA
    } grant_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output grant_t grant,
    output logic   valid
);

    always_comb begin
        valid = i_req | d_req;
        grant = GNT_FETCH;
        if (i_req && d_req) begin
            grant = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (d_req) begin
            grant = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single CPU memory between instruction fetch and load/store: round-robin
// grant, MEM_LAT-cycle access with latched address/data, one-cycle ack with registered data.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_R,
    output logic          mem_W,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LAT - 1);

    arb_state_t       state_q, state_d;
    grant_t           last_grant_q, last_grant_d;
    grant_t           grant_q, grant_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             we_q, we_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DW-1:0]    i_rdata_q, i_rdata_d;
    logic [DW-1:0]    d_rdata_q, d_rdata_d;

    grant_t rr_last;
    grant_t rr_grant;
    logic   rr_valid;

    // In RESP the access just finishing counts as the last grant, so held requests alternate.
    assign rr_last = (state_q == RESP) ? grant_q : last_grant_q;

    mem_arb_rr u_rr (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (rr_last),
        .grant      (rr_grant),
        .valid      (rr_valid)
    );

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE, RESP: begin
                if (state_q == RESP) begin
                    last_grant_d = grant_q;
                end
                state_d = IDLE;
                if (rr_valid) begin
                    state_d    = ACCESS;
                    grant_d    = rr_grant;
                    wait_cnt_d = WAIT_INIT;
                    if (rr_grant == GNT_DATA) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt_q == '0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (grant_q == GNT_FETCH) begin
                            i_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_FETCH;
            grant_q      <= GNT_FETCH;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wait_cnt_q   <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Write strobe only in the last access cycle, so memory sees one write with settled inputs.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_R     = (state_q == ACCESS) && !we_q;
    assign mem_W     = (state_q == ACCESS) && we_q && (wait_cnt_q == '0);
    assign i_ack     = (state_q == RESP) && (grant_q == GNT_FETCH);
    assign d_ack     = (state_q == RESP) && (grant_q == GNT_DATA);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter instances (MEM_LAT 1 and 3), each checked every cycle against a
// transaction-level model of arbitration order, access timing and memory contents.
module tb_mem_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 100;

    int n_vec = 0;
    int n_bad = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int idx);
        return (idx == 1024) ? 32'h8c01_0001 : DW'(idx);
    endfunction

    for (genvar k = 0; k < 2; k++) begin : lane
        localparam int LAT = (k == 0) ? 1 : 3;

        logic          rst, i_req, i_ack, d_req, d_we, d_ack, mem_R, mem_W, busy;
        logic [AW-1:0] i_addr, d_addr, mem_addr;
        logic [DW-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
        bit            done = 1'b0;

        mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
            .clk       (clk),
            .rst       (rst),
            .i_req     (i_req),
            .i_addr    (i_addr),
            .i_ack     (i_ack),
            .i_rdata   (i_rdata),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_ack     (d_ack),
            .d_rdata   (d_rdata),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_R     (mem_R),
            .mem_W     (mem_W),
            .mem_rdata (mem_rdata),
            .busy      (busy)
        );

        // Bench memory: combinational read while R is high, write on the edge ending a W cycle.
        logic [DW-1:0] mem [0:2047];
        bit            mem_ok = 1'b0;
        assign mem_rdata = mem_R ? mem[mem_addr[10:0]] : 32'hDEAD_BEEF;
        always @(posedge clk) begin
            if (!mem_ok) begin
                for (int a = 0; a < 2048; a++) mem[a] <= init_word(a);
                mem_ok <= 1'b1;
            end else if (mem_W) begin
                mem[mem_addr[10:0]] <= mem_wdata;
            end
        end

        task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
            n_vec++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL lat%0d %s @%0t: got 0x%0h, want 0x%0h", LAT, name, $time, got, want);
            end
        endtask

        // Reference model: one transaction at a time, timed by cycle numbers.
        int            cyc = 0;
        int            free_at = 0;
        bit            last_data = 1'b0;
        bit            live = 1'b0;
        bit            post_rst = 1'b0;
        bit            g_data, g_we;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wdata;
        int            t_start, t_ack;
        logic [DW-1:0] exp_i_rdata = '0;
        logic [DW-1:0] exp_d_rdata = '0;
        logic [DW-1:0] shadow [0:2047];

        initial begin
            for (int a = 0; a < 2048; a++) shadow[a] = init_word(a);
            forever begin
                @(posedge clk);
                cyc++;
                post_rst = 1'b0;
                if (live && cyc == t_ack) begin
                    if (g_we)        shadow[g_addr[10:0]] = g_wdata;
                    else if (g_data) exp_d_rdata = shadow[g_addr[10:0]];
                    else             exp_i_rdata = shadow[g_addr[10:0]];
                end
                if (rst) begin
                    live        = 1'b0;
                    last_data   = 1'b0;
                    free_at     = cyc + 1;
                    exp_i_rdata = '0;
                    exp_d_rdata = '0;
                    post_rst    = 1'b1;
                end else if (cyc >= free_at && (i_req || d_req)) begin
                    g_data    = d_req && (!i_req || !last_data);
                    last_data = g_data;
                    g_we      = g_data && d_we;
                    g_addr    = g_data ? d_addr : i_addr;
                    g_wdata   = d_wdata;
                    live      = 1'b1;
                    t_start   = cyc;
                    t_ack     = cyc + LAT;
                    free_at   = t_ack + 1;
                end
            end
        end

        initial begin
            forever begin
                bit in_acc, in_resp;
                @(negedge clk);
                if (cyc > 0) begin
                    in_acc  = live && cyc >= t_start && cyc < t_ack;
                    in_resp = live && cyc == t_ack;
                    check("busy", busy, in_acc || in_resp);
                    check("i_ack", i_ack, in_resp && !g_data);
                    check("d_ack", d_ack, in_resp && g_data);
                    check("mem_R", mem_R, in_acc && !g_we);
                    check("mem_W", mem_W, in_acc && g_we && cyc == t_ack - 1);
                    check("ack_excl", i_ack && d_ack, 0);
                    check("i_rdata", i_rdata, exp_i_rdata);
                    check("d_rdata", d_rdata, exp_d_rdata);
                    if (in_acc) check("mem_addr", mem_addr, g_addr);
                    if (in_acc && g_we) check("mem_wdata", mem_wdata, g_wdata);
                    if (post_rst) begin
                        check("rst_mem_addr", mem_addr, 0);
                        check("rst_mem_wdata", mem_wdata, 0);
                    end
                end
            end
        end

        // Single-requester access; called and returning at a falling edge.
        task automatic access(input bit data, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, output int lat, output int wcyc,
                              output int rcyc);
            bit got;
            lat = 0; wcyc = 0; rcyc = 0; got = 1'b0;
            if (data) begin
                d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
            end else begin
                i_req = 1'b1; i_addr = addr;
            end
            while (!got && lat < TIMEOUT) begin
                @(negedge clk);
                lat++;
                wcyc += int'(mem_W);
                rcyc += int'(mem_R);
                got = data ? d_ack : i_ack;
            end
            check("ack_seen", got, 1);
            if (data) d_req = 1'b0;
            else      i_req = 1'b0;
        endtask

        initial begin
            int lat, wc, rc, n, nack;
            // NOTE: inputs change on the falling edge with blocking writes, clear of the sampling edge.
            rst = 1'b1; i_req = 1'b0; i_addr = '0;
            d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
            repeat (3) @(negedge clk);
            check("reset_busy", busy, 0);
            check("reset_acks", {i_ack, d_ack}, 0);
            check("reset_rw", {mem_R, mem_W}, 0);
            check("reset_rdata", {i_rdata, d_rdata}, 0);
            rst = 1'b0;
            @(negedge clk);

            access(1'b0, 1'b0, 32'd1024, '0, lat, wc, rc);
            check("fetch_latency", lat, LAT + 1);
            check("fetch_rdata", i_rdata, 32'h8c01_0001);
            check("fetch_no_write", wc, 0);

            access(1'b1, 1'b1, 32'd5, 32'd3, lat, wc, rc);
            check("store_w_cycles", wc, 1);
            check("store_mem5", mem[5], 32'd3);
            check("store_keeps_d_rdata", d_rdata, 0);
            access(1'b1, 1'b0, 32'd5, '0, lat, wc, rc);
            check("load_back", d_rdata, 32'd3);

            access(1'b1, 1'b0, 32'd7, '0, lat, wc, rc);
            check("load7_latency", lat, LAT + 1);
            check("load7_r_cycles", rc, LAT);
            check("load7_data", d_rdata, 32'd7);

            // Both requesters held from reset: DATA first, then strict alternation, no bubbles.
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            i_req = 1'b1; i_addr = 32'd1028; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd11;
            n = 0; nack = 0;
            while (nack < 6 && n < 6 * TIMEOUT) begin
                @(negedge clk);
                n++;
                if (i_ack || d_ack) begin
                    nack++;
                    check("alt_order_data", d_ack, nack % 2);
                    check("alt_cycle", n, nack * (LAT + 1));
                end
            end
            check("alt_acks", nack, 6);
            i_req = 1'b0; d_req = 1'b0;
            check("alt_i_rdata", i_rdata, 32'd1028);
            check("alt_d_rdata", d_rdata, 32'd11);

            // Reset during the first access cycle of a store.
            @(negedge clk);
            d_req = 1'b1; d_we = 1'b1; d_addr = 32'd9; d_wdata = 32'h0000_abcd;
            @(negedge clk);
            check("abort_in_access", busy, 1);
            rst = 1'b1; d_req = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_mem_addr", mem_addr, 0);
            check("abort_d_rdata", d_rdata, 0);
            repeat (LAT + 2) begin
                @(negedge clk);
                check("abort_no_ack", d_ack, 0);
            end
            check("abort_mem9", mem[9], (LAT == 1) ? 32'h0000_abcd : 32'd9);

            // Random concurrent traffic from both requesters.
            fork
                begin
                    for (int t = 0; t < 120; t++) begin
                        int w;
                        bit got;
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        i_addr = 32'd1024 + 32'(4 * $urandom_range(0, 255));
                        i_req  = 1'b1;
                        w = 0; got = 1'b0;
                        while (!got && w < TIMEOUT) begin
                            @(negedge clk);
                            w++;
                            got = i_ack;
                        end
                        check("rnd_i_ack", got, 1);
                        i_req = 1'b0;
                    end
                end
                begin
                    for (int t = 0; t < 120; t++) begin
                        int w;
                        bit got;
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        d_we    = 1'($urandom_range(0, 1));
                        d_addr  = 32'($urandom_range(0, 15));
                        d_wdata = $urandom;
                        d_req   = 1'b1;
                        w = 0; got = 1'b0;
                        while (!got && w < TIMEOUT) begin
                            @(negedge clk);
                            w++;
                            got = d_ack;
                        end
                        check("rnd_d_ack", got, 1);
                        d_req = 1'b0;
                    end
                end
            join
            repeat (2) @(negedge clk);
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(lane[0].done && lane[1].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) begin
            n_bad++;
            $display("FAIL global_timeout: got %0d cycles, want fewer than 20000", t);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
